// File: rtl/sd_multiblock_bridge.sv
// rtl/sd_multiblock_bridge.sv - host-side SD sector bridge with per-drive requests, multi-sector LBA stepping and request timeout
module sd_multiblock_bridge #(
    parameter int NDRIVES = 2,
    parameter int LBA_W   = 27,
    parameter int WORD_W  = 16,
    parameter int AW      = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000000,
    localparam int DW     = (NDRIVES > 1) ? $clog2(NDRIVES) : 1
) (
    input  logic               controller_clk,
    input  logic               reset,
    input  logic [DW-1:0]      host_drive,
    input  logic [LBA_W-1:0]   host_lba,
    input  logic [CNT_W-1:0]   host_count,
    input  logic               host_read_start,
    input  logic               host_write_start,
    input  logic               host_ack,
    output logic               host_idle,
    output logic               host_done,
    output logic               host_error,
    output logic [CNT_W-1:0]   host_sector,
    input  logic [AW-1:0]      host_xfer_addr,
    input  logic [WORD_W-1:0]  host_xfer_in,
    input  logic               host_xfer_write,
    output logic [WORD_W-1:0]  host_xfer_out,
    output logic [31:0]        sd_lba,
    output logic [NDRIVES-1:0] sd_rd,
    output logic [NDRIVES-1:0] sd_wr,
    input  logic [NDRIVES-1:0] sd_ack,
    input  logic [AW-1:0]      sd_buff_addr,
    input  logic [WORD_W-1:0]  sd_buff_dout,
    input  logic               sd_buff_wr,
    output logic [WORD_W-1:0]  sd_buff_din,
    output logic [2:0]         state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_XFER    = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4,
        S_WAITW   = 3'd5
    } state_t;

    state_t state, state_next;

    logic               op_write;
    logic [DW-1:0]      drv_q;
    logic [LBA_W-1:0]   lba_q;
    logic [CNT_W-1:0]   last_q;
    logic [CNT_W-1:0]   sector_q;
    logic               error_q;
    logic [TW-1:0]      timer;

    logic               latch, advance, set_err, clr_err;
    logic               drive_bad;
    logic [NDRIVES-1:0] req_mask;
    logic               ack_sel;

    logic [WORD_W-1:0]  rbuf [2**AW];
    logic [WORD_W-1:0]  wbuf [2**AW];

    assign drive_bad = 32'(host_drive) >= 32'(NDRIVES);
    assign req_mask  = NDRIVES'(1) << drv_q;
    // Acks from drives other than the latched one never influence the FSM.
    assign ack_sel   = |(sd_ack & req_mask);

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        advance    = 1'b0;
        set_err    = 1'b0;
        clr_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!host_ack && (host_read_start || host_write_start)) begin
                    if ((host_read_start && host_write_start) || drive_bad) begin
                        state_next = S_DONE;
                        set_err    = 1'b1;
                    end else begin
                        latch      = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (ack_sel) begin
                    state_next = S_XFER;
                end else if (timer == TLIM) begin
                    state_next = S_DONE;
                    set_err    = 1'b1;
                end
            end
            S_XFER: begin
                if (!ack_sel) state_next = S_DONE;
            end
            S_DONE: begin
                if (host_ack) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!host_ack) begin
                    clr_err = 1'b1;
                    if (error_q || sector_q == last_q) begin
                        state_next = S_IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = op_write ? S_WAITW : S_REQ;
                    end
                end
            end
            S_WAITW: begin
                if (host_write_start) begin
                    state_next = S_REQ;
                end else if (host_read_start) begin
                    state_next = S_DONE;
                    set_err    = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge controller_clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_write <= 1'b0;
            drv_q    <= '0;
            lba_q    <= '0;
            last_q   <= '0;
            sector_q <= '0;
            error_q  <= 1'b0;
            timer    <= '0;
        end else begin
            state <= state_next;
            // Timer restarts from zero on every entry into REQ.
            if (state != S_REQ) timer <= '0;
            else                timer <= timer + TW'(1);
            if (set_err)      error_q <= 1'b1;
            else if (clr_err) error_q <= 1'b0;
            if (latch) begin
                drv_q    <= host_drive;
                lba_q    <= host_lba;
                op_write <= host_write_start;
                last_q   <= (host_count == '0) ? '0 : host_count - CNT_W'(1);
                sector_q <= '0;
            end else if (advance) begin
                lba_q    <= lba_q + LBA_W'(1);
                sector_q <= sector_q + CNT_W'(1);
            end
        end
    end

    // Buffer arrays carry no reset so sector data survives a mid-transfer reset.
    always_ff @(posedge controller_clk) begin
        if (sd_buff_wr && state == S_XFER && !op_write)
            rbuf[sd_buff_addr] <= sd_buff_dout;
        if (host_xfer_write && !(op_write && (state == S_REQ || state == S_XFER)))
            wbuf[host_xfer_addr] <= host_xfer_in;
    end

    always_ff @(posedge controller_clk) begin
        if (reset) begin
            host_xfer_out <= '0;
            sd_buff_din   <= '0;
        end else begin
            host_xfer_out <= rbuf[host_xfer_addr];
            sd_buff_din   <= wbuf[sd_buff_addr];
        end
    end

    assign host_idle   = (state == S_IDLE);
    assign host_done   = (state == S_DONE);
    assign host_error  = error_q;
    assign host_sector = sector_q;
    assign sd_lba      = 32'(lba_q);
    assign sd_rd       = (state == S_REQ && !op_write) ? req_mask : '0;
    assign sd_wr       = (state == S_REQ &&  op_write) ? req_mask : '0;
    assign state_dbg   = state;

endmodule

// File: tb/tb_sd_multiblock_bridge.sv
// tb/tb_sd_multiblock_bridge.sv - directed self-checking bench for sd_multiblock_bridge
module tb_sd_multiblock_bridge;

    logic        controller_clk = 1'b0;
    logic        reset;
    logic [1:0]  host_drive;
    logic [26:0] host_lba;
    logic [7:0]  host_count;
    logic        host_read_start, host_write_start, host_ack;
    logic        host_idle, host_done, host_error;
    logic [7:0]  host_sector;
    logic [7:0]  host_xfer_addr;
    logic [15:0] host_xfer_in;
    logic        host_xfer_write;
    logic [15:0] host_xfer_out;
    logic [31:0] sd_lba;
    logic [2:0]  sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    sd_multiblock_bridge #(
        .NDRIVES(3), .LBA_W(27), .WORD_W(16), .AW(8), .CNT_W(8), .TIMEOUT(50)
    ) dut (
        .controller_clk(controller_clk), .reset(reset),
        .host_drive(host_drive), .host_lba(host_lba), .host_count(host_count),
        .host_read_start(host_read_start), .host_write_start(host_write_start),
        .host_ack(host_ack), .host_idle(host_idle), .host_done(host_done),
        .host_error(host_error), .host_sector(host_sector),
        .host_xfer_addr(host_xfer_addr), .host_xfer_in(host_xfer_in),
        .host_xfer_write(host_xfer_write), .host_xfer_out(host_xfer_out),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .state_dbg(state_dbg)
    );

    always #5 controller_clk = ~controller_clk;

    task automatic tick();
        @(posedge controller_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ack_handshake();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_lba [3];
        int cnt;
        exp_lba[0] = 32'h07FFFFFE;
        exp_lba[1] = 32'h07FFFFFF;
        exp_lba[2] = 32'h00000000;

        reset = 1'b1;
        host_drive = '0; host_lba = '0; host_count = '0;
        host_read_start = 0; host_write_start = 0; host_ack = 0;
        host_xfer_addr = '0; host_xfer_in = '0; host_xfer_write = 0;
        sd_ack = '0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
        tick();
        tick();
        check("rst_idle", 32'(host_idle), 32'd1);
        check("rst_done", 32'(host_done), 32'd0);
        check("rst_error", 32'(host_error), 32'd0);
        check("rst_sector", 32'(host_sector), 32'd0);
        check("rst_sd_rd", 32'(sd_rd), 32'd0);
        check("rst_sd_wr", 32'(sd_wr), 32'd0);
        check("rst_sd_lba", sd_lba, 32'd0);
        check("rst_xfer_out", 32'(host_xfer_out), 32'd0);
        check("rst_buff_din", 32'(sd_buff_din), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        tick();

        // Single-sector read from drive 0
        host_drive = 2'd0; host_lba = 27'h123; host_count = 8'd1; host_read_start = 1;
        tick();
        check("rd1_req", 32'(sd_rd), 32'b001);
        check("rd1_lba", sd_lba, 32'h123);
        check("rd1_state", 32'(state_dbg), 32'd1);
        host_read_start = 0;
        for (int i = 0; i < 4; i++) tick();
        check("rd1_req_held", 32'(sd_rd), 32'b001);
        sd_ack = 3'b001;
        tick();
        check("rd1_xfer_drop", 32'(sd_rd), 32'd0);
        check("rd1_xfer_state", 32'(state_dbg), 32'd2);
        for (int k = 0; k < 256; k++) begin
            sd_buff_addr = 8'(k);
            sd_buff_dout = 16'(k) ^ 16'hA5A5;
            sd_buff_wr = 1;
            tick();
        end
        sd_buff_wr = 0;
        sd_ack = '0;
        tick();
        check("rd1_done", 32'(host_done), 32'd1);
        check("rd1_error", 32'(host_error), 32'd0);
        host_ack = 1;
        tick();
        check("rd1_release_done", 32'(host_done), 32'd0);
        host_ack = 0;
        tick();
        check("rd1_idle", 32'(host_idle), 32'd1);
        for (int k = 0; k < 256; k++) begin
            host_xfer_addr = 8'(k);
            tick();
            check("rd1_rbuf", 32'(host_xfer_out), 32'(16'(k) ^ 16'hA5A5));
        end
        sd_buff_addr = 8'd0; sd_buff_dout = 16'hFFFF; sd_buff_wr = 1;
        tick();
        sd_buff_wr = 0;
        host_xfer_addr = 8'd0;
        tick();
        check("rbuf_strobe_idle_ignored", 32'(host_xfer_out), 32'hA5A5);

        // Three-sector read across the LBA wrap
        host_lba = 27'h7FFFFFE; host_count = 8'd3; host_read_start = 1;
        tick();
        host_read_start = 0;
        for (int s = 0; s < 3; s++) begin
            check("mr_lba", sd_lba, exp_lba[s]);
            check("mr_sector", 32'(host_sector), 32'(s));
            check("mr_req", 32'(sd_rd), 32'b001);
            sd_ack = 3'b001;
            tick();
            sd_ack = '0;
            tick();
            check("mr_done", 32'(host_done), 32'd1);
            ack_handshake();
        end
        check("mr_idle", 32'(host_idle), 32'd1);

        // Two-sector write on drive 1
        host_xfer_write = 1;
        for (int k = 0; k < 256; k++) begin
            host_xfer_addr = 8'(k);
            host_xfer_in = 16'h1000 + 16'(k * 3);
            tick();
        end
        host_xfer_write = 0;
        host_drive = 2'd1; host_lba = 27'h40; host_count = 8'd2; host_write_start = 1;
        tick();
        check("wr_req", 32'(sd_wr), 32'b010);
        check("wr_no_rd", 32'(sd_rd), 32'd0);
        host_write_start = 0;
        sd_ack = 3'b010;
        tick();
        host_xfer_addr = 8'd5; host_xfer_in = 16'hDEAD; host_xfer_write = 1;
        tick();
        host_xfer_write = 0;
        sd_buff_addr = 8'd0;
        tick();
        check("wr_din0", 32'(sd_buff_din), 32'h1000);
        sd_buff_addr = 8'd5;
        tick();
        check("wr_din5_protected", 32'(sd_buff_din), 32'h100F);
        sd_buff_addr = 8'd255;
        tick();
        check("wr_din255", 32'(sd_buff_din), 32'(16'h1000 + 16'(255 * 3)));
        sd_ack = '0;
        tick();
        check("wr_done", 32'(host_done), 32'd1);
        ack_handshake();
        check("wr_waitw", 32'(state_dbg), 32'd5);
        check("wr_lba2", sd_lba, 32'h41);
        check("wr_sector2", 32'(host_sector), 32'd1);
        tick();
        tick();
        check("wr_waitw_hold", 32'(state_dbg), 32'd5);
        check("wr_waitw_no_req", 32'(sd_wr), 32'd0);
        host_xfer_addr = 8'd7; host_xfer_in = 16'hBEEF; host_xfer_write = 1;
        tick();
        host_xfer_write = 0;
        host_write_start = 1;
        tick();
        check("wr2_req", 32'(sd_wr), 32'b010);
        host_write_start = 0;
        sd_ack = 3'b010;
        tick();
        sd_buff_addr = 8'd7;
        tick();
        check("wr2_refill", 32'(sd_buff_din), 32'hBEEF);
        sd_ack = '0;
        tick();
        ack_handshake();
        check("wr_idle", 32'(host_idle), 32'd1);

        // Timeout with an unrelated drive acking
        host_drive = 2'd0; host_lba = 27'h10; host_count = 8'd1; host_read_start = 1;
        tick();
        host_read_start = 0;
        sd_ack = 3'b010;
        cnt = 0;
        while (sd_rd[0] && cnt < 100) begin
            cnt++;
            tick();
        end
        sd_ack = '0;
        check("to_cycles", 32'(cnt), 32'd50);
        check("to_done", 32'(host_done), 32'd1);
        check("to_error", 32'(host_error), 32'd1);
        host_ack = 1;
        tick();
        check("to_err_held", 32'(host_error), 32'd1);
        host_ack = 0;
        tick();
        check("to_err_clr", 32'(host_error), 32'd0);
        check("to_idle", 32'(host_idle), 32'd1);

        // Bad requests
        host_drive = 2'd3; host_read_start = 1;
        tick();
        host_read_start = 0;
        check("bad_drv_done", 32'(host_done), 32'd1);
        check("bad_drv_error", 32'(host_error), 32'd1);
        check("bad_drv_no_req", 32'(sd_rd), 32'd0);
        ack_handshake();
        check("bad_drv_idle", 32'(host_idle), 32'd1);
        host_drive = 2'd0; host_read_start = 1; host_write_start = 1;
        tick();
        check("both_done", 32'(host_done), 32'd1);
        check("both_error", 32'(host_error), 32'd1);
        check("both_no_req", 32'({sd_rd, sd_wr}), 32'd0);
        tick();
        check("both_no_retrigger", 32'(state_dbg), 32'd3);
        host_read_start = 0; host_write_start = 0;
        ack_handshake();

        // Reset in XFER of the second of four sectors
        host_lba = 27'h200; host_count = 8'd4; host_read_start = 1;
        tick();
        host_read_start = 0;
        sd_ack = 3'b001;
        tick();
        sd_ack = '0;
        tick();
        ack_handshake();
        sd_ack = 3'b001;
        tick();
        check("mid_sector", 32'(host_sector), 32'd1);
        check("mid_xfer", 32'(state_dbg), 32'd2);
        for (int k = 0; k < 4; k++) begin
            sd_buff_addr = 8'(k);
            sd_buff_dout = 16'h5500 + 16'(k);
            sd_buff_wr = 1;
            tick();
        end
        sd_buff_wr = 0;
        reset = 1;
        tick();
        check("mid_rst_sd_rd", 32'(sd_rd), 32'd0);
        check("mid_rst_idle", 32'(host_idle), 32'd1);
        check("mid_rst_sector", 32'(host_sector), 32'd0);
        check("mid_rst_out", 32'(host_xfer_out), 32'd0);
        reset = 0;
        sd_ack = '0;
        for (int k = 0; k < 4; k++) begin
            host_xfer_addr = 8'(k);
            tick();
            check("mid_rbuf_kept", 32'(host_xfer_out), 32'(16'h5500 + 16'(k)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
